// File: rtl/reg_bank_write_arbiter.sv
// Round-robin, burst-granular write arbiter sharing one register bank among NUM_REQ writers.
// Optional per-requester burst-grant counters are enabled by defining ARB_GRANT_STATS_EN.
module reg_bank_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int BIT_WIDTH  = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic [(1<<ADDR_WIDTH)-1:0]      reg_wrtEn,
  output logic [BIT_WIDTH-1:0]            reg_dataIn,
  output logic                            burst_err,
`ifdef ARB_GRANT_STATS_EN
  output logic [NUM_REQ*16-1:0]           grant_count,
`endif
  output logic                            dbg_state
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int PW   = $clog2(NUM_REQ);
  localparam int CW   = $clog2(MAX_BURST + 1);

  // Handshake: a beat transfers on a rising edge where req_valid[g] & req_ready[g];
  // req_ready is high only for the granted requester while in BURST.

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q;
  logic [PW-1:0]           gidx_q;
  logic [CW-1:0]           count_q;
  logic [ADDR_WIDTH-1:0]   base_q;

  logic [ADDR_WIDTH-1:0]   addr_a [NUM_REQ];
  logic [BIT_WIDTH-1:0]    data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[i] = req_data[i*BIT_WIDTH +: BIT_WIDTH];
  end

  logic                  arb_found;
  logic [PW-1:0]         arb_idx;
  logic                  g_valid;
  logic                  g_last;
  logic                  accept;
  logic                  at_max;
  logic                  burst_end;
  logic [CW-1:0]         count_inc;
  logic [ADDR_WIDTH-1:0] beat_addr;

  // Search starts just after the last owner, so the last owner has lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!arb_found && req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = PW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign g_valid   = req_valid[gidx_q];
  assign g_last    = req_last[gidx_q];
  assign accept    = (state_q == BURST) && g_valid;
  assign count_inc = count_q + CW'(1);
  assign at_max    = (count_inc == CW'(MAX_BURST));
  assign burst_end = accept && (g_last || at_max);
  // First beat uses the live address; later beats walk from the latched base and wrap.
  assign beat_addr = (count_q == '0) ? addr_a[gidx_q] : base_q + ADDR_WIDTH'(count_q);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) state_d = BURST;
      end
      BURST: begin
        req_ready = grant;
        if (burst_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = (state_q == BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NUM_REQ - 1);
      gidx_q     <= '0;
      grant      <= '0;
      count_q    <= '0;
      base_q     <= '0;
      reg_wrtEn  <= '0;
      reg_dataIn <= '0;
      burst_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_wrtEn <= '0;
      burst_err <= 1'b0;
      if (state_q == IDLE && arb_found) begin
        gidx_q  <= arb_idx;
        grant   <= NUM_REQ'(1) << arb_idx;
        count_q <= '0;
      end
      if (accept) begin
        reg_wrtEn  <= NREG'(1) << beat_addr;
        reg_dataIn <= data_a[gidx_q];
        count_q    <= count_inc;
        if (count_q == '0) base_q <= addr_a[gidx_q];
        if (burst_end) begin
          grant     <= '0;
          ptr_q     <= gidx_q;
          count_q   <= '0;
          burst_err <= !g_last && at_max;
        end
      end
    end
  end

`ifdef ARB_GRANT_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state_q == IDLE && arb_found && cnt_q[arb_idx] != 16'hFFFF) begin
      cnt_q[arb_idx] <= cnt_q[arb_idx] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    assign grant_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Self-checking bench for reg_bank_write_arbiter: directed scenarios plus random traffic
// compared against an integer-level behavioural model and a write scoreboard.
module tb_reg_bank_write_arbiter;

  localparam int N    = 4;
  localparam int AW   = 3;
  localparam int BW   = 32;
  localparam int MAXB = 8;
  localparam int NREG = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_last;
  logic [N*AW-1:0]     req_addr;
  logic [N*BW-1:0]     req_data;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        grant;
  logic [NREG-1:0]     reg_wrtEn;
  logic [BW-1:0]       reg_dataIn;
  logic                burst_err;
  logic                dbg_state;
`ifdef ARB_GRANT_STATS_EN
  logic [N*16-1:0]     grant_count;
`endif

  reg_bank_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BIT_WIDTH(BW), .MAX_BURST(MAXB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .grant      (grant),
    .reg_wrtEn  (reg_wrtEn),
    .reg_dataIn (reg_dataIn),
    .burst_err  (burst_err),
`ifdef ARB_GRANT_STATS_EN
    .grant_count(grant_count),
`endif
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_owner = -1;
  int              m_ptr   = N - 1;
  int              m_k     = 0;
  int              m_base  = 0;
  int              m_cnt [N];
  logic [N-1:0]    exp_grant = '0;
  logic [NREG-1:0] exp_wr    = '0;
  logic [BW-1:0]   exp_data  = '0;
  logic            exp_err   = 1'b0;

  logic [NREG+BW-1:0] exp_q [$];
  logic [NREG-1:0]    obs_wr [$];
  int                 obs_g [$];
  int                 err_cnt = 0;
  logic [N-1:0]       prev_grant = '0;

  task automatic model_step();
    int a;
    if (reset) begin
      m_owner = -1; m_ptr = N - 1; m_k = 0; m_base = 0;
      exp_grant = '0; exp_wr = '0; exp_data = '0; exp_err = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      exp_q.delete();
      return;
    end
    exp_wr  = '0;
    exp_err = 1'b0;
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (m_owner < 0 && req_valid[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      end
      if (m_owner >= 0) begin
        exp_grant = N'(1) << m_owner;
        m_k = 0;
        if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
      end
    end else if (req_valid[m_owner]) begin
      if (m_k == 0) m_base = int'(req_addr[m_owner*AW +: AW]);
      a = (m_base + m_k) % NREG;
      exp_wr   = NREG'(1) << a;
      exp_data = req_data[m_owner*BW +: BW];
      exp_q.push_back({exp_wr, exp_data});
      m_k++;
      if (req_last[m_owner] || m_k == MAXB) begin
        exp_err   = !req_last[m_owner];
        m_ptr     = m_owner;
        m_owner   = -1;
        m_k       = 0;
        exp_grant = '0;
      end
    end
  endtask

  // ---------------- per-cycle driver/monitor ----------------
  task automatic post_check();
    logic [NREG+BW-1:0] e;
    check("grant", grant, exp_grant);
    check("wrtEn", reg_wrtEn, exp_wr);
    check("dataIn", reg_dataIn, exp_data);
    check("burst_err", burst_err, exp_err);
    check("dbg_state", dbg_state, m_owner >= 0);
    if (reg_wrtEn != '0) begin
      if (exp_q.size() == 0) check("wr_unexpected", reg_wrtEn, '0);
      else begin
        e = exp_q.pop_front();
        check("wr_txn", {reg_wrtEn, reg_dataIn}, e);
      end
      obs_wr.push_back(reg_wrtEn);
    end
    if (burst_err) err_cnt++;
    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) obs_g.push_back(i);
    end
    prev_grant = grant;
`ifdef ARB_GRANT_STATS_EN
    for (int i = 0; i < N; i++) check("grant_count", grant_count[i*16 +: 16], 16'(m_cnt[i]));
`endif
  endtask

  task automatic tick();
    logic [N-1:0] er;
    er = (m_owner >= 0) ? N'(1) << m_owner : '0;
    check("req_ready", req_ready, er);
    model_step();
    @(posedge clk);
    @(negedge clk);
    post_check();
  endtask

  task automatic set_req(input int r, input logic v, input logic l, input int a, input logic [BW-1:0] d);
    req_valid[r]         = v;
    req_last[r]          = l;
    req_addr[r*AW +: AW] = AW'(a);
    req_data[r*BW +: BW] = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;
  endtask

  task automatic clear_obs();
    obs_wr.delete(); obs_g.delete(); err_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic send_burst(input int r, input int a, input int len, input bit use_last, input logic [BW-1:0] d0);
    int  beat  = 0;
    int  guard = 0;
    logic acc;
    while (beat < len && guard < 200) begin
      set_req(r, 1'b1, use_last && (beat == len - 1), a, d0 + BW'(beat));
      acc = req_ready[r];
      tick();
      guard++;
      if (acc) beat++;
    end
    check("send_timeout", beat, len);
    set_req(r, 1'b0, 1'b0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    clear_inputs();
    reset = 1'b1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    post_check();
    reset = 1'b0;
    clear_obs();

    // 3-beat burst from requester 0 at address 2
    send_burst(0, 2, 3, 1'b1, 32'hA0);
    repeat (3) tick();
    check("t1_nwr", obs_wr.size(), 3);
    check("t1_wr0", obs_wr[0], 8'h04);
    check("t1_wr1", obs_wr[1], 8'h08);
    check("t1_wr2", obs_wr[2], 8'h10);
    check("t1_grant_idle", grant, '0);

    // round robin between 1 and 3
    do_reset();
    set_req(1, 1'b1, 1'b1, 1, 32'h11);
    set_req(3, 1'b1, 1'b1, 3, 32'h33);
    repeat (9) tick();
    clear_inputs();
    repeat (3) tick();
    check("t2a_g0", obs_g[0], 1);
    check("t2a_g1", obs_g[1], 3);
    check("t2a_g2", obs_g[2], 1);
    check("t2a_g3", obs_g[3], 3);

    // round robin among 0,1,2
    do_reset();
    set_req(0, 1'b1, 1'b1, 0, 32'h100);
    set_req(1, 1'b1, 1'b1, 1, 32'h101);
    set_req(2, 1'b1, 1'b1, 2, 32'h102);
    repeat (9) tick();
    clear_inputs();
    repeat (3) tick();
    check("t2b_g0", obs_g[0], 0);
    check("t2b_g1", obs_g[1], 1);
    check("t2b_g2", obs_g[2], 2);
    check("t2b_g3", obs_g[3], 0);

    // address wrap-around
    do_reset();
    send_burst(2, 6, 4, 1'b1, 32'hC0DE0000);
    repeat (3) tick();
    check("t3_nwr", obs_wr.size(), 4);
    check("t3_wr0", obs_wr[0], 8'h40);
    check("t3_wr1", obs_wr[1], 8'h80);
    check("t3_wr2", obs_wr[2], 8'h01);
    check("t3_wr3", obs_wr[3], 8'h02);

    // burst cut at MAX_BURST without last
    do_reset();
    send_burst(0, 0, 10, 1'b0, 32'hBEEF0000);
    repeat (3) tick();
    check("t4_nwr", obs_wr.size(), 10);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_wr7", obs_wr[7], 8'h80);
    check("t4_wr8", obs_wr[8], 8'h01);

    // reset in the middle of a burst
    do_reset();
    begin
      int acc_cnt = 0;
      int guard   = 0;
      logic acc;
      while (acc_cnt < 2 && guard < 50) begin
        set_req(2, 1'b1, 1'b0, 1, 32'h5000 + BW'(acc_cnt));
        acc = req_ready[2];
        tick();
        guard++;
        if (acc) acc_cnt++;
      end
      check("t5_beats", acc_cnt, 2);
    end
    set_req(0, 1'b1, 1'b1, 4, 32'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_wr_after_rst", reg_wrtEn, '0);
    check("t5_grant_after_rst", grant, '0);
    clear_obs();
    repeat (2) tick();
    check("t5_first_winner", obs_g[0], 0);
    clear_inputs();
    repeat (3) tick();

`ifdef ARB_GRANT_STATS_EN
    do_reset();
    for (int b = 0; b < 5; b++) begin
      send_burst(1, b, 2, 1'b1, 32'h1000);
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      send_burst(3, b, 1, 1'b1, 32'h3000);
      tick();
    end
    repeat (2) tick();
    check("t6_cnt0", grant_count[0*16 +: 16], 16'd0);
    check("t6_cnt1", grant_count[1*16 +: 16], 16'd5);
    check("t6_cnt2", grant_count[2*16 +: 16], 16'd0);
    check("t6_cnt3", grant_count[3*16 +: 16], 16'd2);
`endif

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int last_pct;
      last_pct = (c < 1500) ? 30 : 4;
      for (int r = 0; r < N; r++) begin
        set_req(r, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < last_pct,
                int'($urandom_range(0, NREG - 1)), $urandom);
      end
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
Shares one bank of 2^ADDR_WIDTH Register instances (BIT_WIDTH each) between NUM_REQ compression-pipeline writers, e.g. dictionary, header and stats stages.
- Round-robin arbitration at burst granularity.
- The granted requester streams beats into consecutive register addresses.
- Drives one-hot wrtEn lines plus a shared dataIn bus to the bank, all registered.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_WIDTH, 3, register-bank address width; bank holds 2^ADDR_WIDTH registers
BIT_WIDTH, 32, register data width
MAX_BURST, 8, maximum beats per grant (1..2^ADDR_WIDTH)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  marks final beat of a burst
req_addr  in  NUM_REQ*ADDR_WIDTH  start address; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]; sampled on first beat only
req_data  in  NUM_REQ*BIT_WIDTH  beat data; requester i in slice [i*BIT_WIDTH +: BIT_WIDTH]
req_ready  out  NUM_REQ  one-hot beat accept; only the granted requester's bit can be high
grant  out  NUM_REQ  one-hot current owner; all zero when idle
reg_wrtEn  out  2^ADDR_WIDTH  one-hot write enables to the register bank
reg_dataIn  out  BIT_WIDTH  shared data to the register bank
burst_err  out  1  one-cycle pulse when a burst is cut at MAX_BURST without last

Behaviour:
- Reset state: grant=0, req_ready=0, reg_wrtEn=0, reg_dataIn=0, burst_err=0, beat count=0, state=IDLE.
- Reset pointer = NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-burst abandons the burst; no write issues on the cycle after reset.
- FSM states IDLE and BURST.
- IDLE: if any req_valid is high, select the first valid index searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Register the winner into grant and go to BURST.
  - req_ready stays 0 in IDLE.
- BURST: req_ready[g] = 1 for the granted index g; the other bits are 0.
  - A beat is accepted when req_valid[g] & req_ready[g].
  - First beat: address = req_addr[g], which is latched as the burst base.
  - Beat k (0-based): address = (base + k) mod 2^ADDR_WIDTH. Wrap-around is legal; later req_addr values are ignored.
  - Accepted beat at cycle t produces, at cycle t+1:
    - reg_wrtEn has exactly the bit for that address set;
    - reg_dataIn = req_data[g].
  - reg_wrtEn is 0 on every cycle that did not follow an accepted beat.
  - req_valid[g] low in BURST: the grant is held, no timeout, no write.
- Burst ends on the accepted beat that has req_last[g]=1, or on the MAX_BURST-th accepted beat.
  - The cycle after the end: state=IDLE, grant=0, ptr=g, count=0.
  - If the end came from reaching MAX_BURST with req_last=0, burst_err pulses for one cycle, aligned with that final reg_wrtEn.
  - The requester's remaining beats are re-arbitrated as a new burst.
- Every burst pays one IDLE cycle, so back-to-back bursts leave at least one write-free cycle between them.
- Requests from non-granted requesters are never accepted; they wait without any ordering change other than round-robin.
- A single beat that is both first and last is a 1-beat burst; this is legal.
- The beat counter is ceil(log2(MAX_BURST+1)) bits wide and never exceeds MAX_BURST.

Optional Feature:
Macro ARB_GRANT_STATS_EN.
- Defined:
  - Adds output grant_count, NUM_REQ*16 bits; slice i counts the bursts granted to requester i.
  - The count increments on the IDLE->BURST transition and saturates at 16'hFFFF.
  - Counts reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then requester 0 sends 3 beats at addr 2 with data A,B,C and last on C -> reg_wrtEn = 0x04, 0x08, 0x10 with reg_dataIn A, B, C, each one cycle after its accept; grant returns to 0 after the burst.
2. Requesters 1 and 3 both valid from reset with 1-beat bursts, held continuously -> grant order is 1, 3, 1, 3. Repeat with 0, 1, 2 valid -> order 0, 1, 2, 0.
3. Requester 2 sends 4 beats at addr 6 with ADDR_WIDTH=3 -> addresses 6, 7, 0, 1 (reg_wrtEn 0x40, 0x80, 0x01, 0x02).
4. Requester 0 sends 10 beats with no last and MAX_BURST=8 -> 8 writes, then burst_err pulses with the 8th write; the next grant is to another valid requester, or to requester 0 again after one IDLE cycle, with remaining beats starting at its new req_addr.
5. Reset asserted after beat 2 of a 5-beat burst -> on the next cycle reg_wrtEn=0 and grant=0; the following arbitration starts from requester 0.
6. With ARB_GRANT_STATS_EN defined, run 5 bursts from requester 1 and 2 from requester 3 -> grant_count slice 1 = 5, slice 3 = 2, others 0.
